// File: rtl/fetch_byte_queue_pkg.sv
// Shared definitions for the fetch byte queue.
//   fq_state_e   : queue FSM states (waiting for the first line after reset/redirect,
//                  or streaming bytes to decode)
//   LINE_BYTES   : bytes per I-cache line
//   SLOTS        : number of line slots in the store
//   PTR_W        : byte pointer width (5 index bits + 1 wrap bit)
//   line_base()  : 16-byte aligned line address containing a byte address
package fetch_byte_queue_pkg;

  localparam int LINE_BYTES = 16;
  localparam int SLOTS      = 2;
  localparam int PTR_W      = 6;

  typedef enum logic [0:0] {
    FQ_WAIT_FIRST = 1'b0,
    FQ_STREAM     = 1'b1
  } fq_state_e;

  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return addr & ~32'hF;
  endfunction

endpackage

// File: rtl/fetch_byte_queue_if.sv
// Bus between the fetch byte queue and its neighbours (I-cache on the line side,
// decode on the packet side).
//
// Handshakes:
//   line   : a line transfers on a clock edge where line_valid & line_ready are both 1,
//            line_addr == fetch_addr and redirect is 0. line_ready does not depend on
//            line_valid. A line whose address differs from fetch_addr is dropped.
//   packet : decode takes the window on an edge where packet_valid & consume are both 1
//            and redirect is 0; consume_len (1..16) bytes are then retired.
//            consume while packet_valid is 0 has no effect.
//   redirect overrides both handshakes in the cycle it is asserted.
//
// Modports: slave = the queue, master = the environment driving it.
interface fetch_byte_queue_if;
  logic         line_valid;
  logic [31:0]  line_addr;
  logic [127:0] line_data;
  logic         line_ready;
  logic [31:0]  fetch_addr;
  logic         redirect;
  logic [31:0]  redirect_addr;
  logic         consume;
  logic [4:0]   consume_len;
  logic         packet_valid;
  logic [127:0] packet_out;
  logic [31:0]  packet_eip;

  modport slave (
    input  line_valid, line_addr, line_data, redirect, redirect_addr, consume, consume_len,
    output line_ready, fetch_addr, packet_valid, packet_out, packet_eip
  );

  modport master (
    output line_valid, line_addr, line_data, redirect, redirect_addr, consume, consume_len,
    input  line_ready, fetch_addr, packet_valid, packet_out, packet_eip
  );
endinterface

// File: rtl/fetch_byte_queue_rotator.sv
// Combinational byte rotator for the fetch byte queue.
//   data_in  [255:0] : 32-byte store, byte b at [8b+7:8b]
//   offset   [4:0]   : byte index that becomes output byte 0
//   data_out [127:0] : byte k = data_in byte (offset + k) mod 32
module fetch_byte_queue_rotator (
  input  logic [255:0] data_in,
  input  logic [4:0]   offset,
  output logic [127:0] data_out
);

  // Doubling the store makes the 31 -> 0 wrap a plain part-select.
  logic [511:0] doubled;

  assign doubled  = {data_in, data_in};
  assign data_out = doubled[{offset, 3'b000} +: 128];

endmodule

// File: rtl/fetch_byte_queue.sv
// Fetch-stage byte queue in front of the F->D latch. Stores two 16-byte I-cache lines
// and presents a 16-byte window starting at the current EIP.
//   clk        : clock, all state on posedge
//   clr        : synchronous active-high reset
//   bus        : line-in / packet-out / redirect signals (see fetch_byte_queue_if)
//   dbg_state  : current FSM state
module fetch_byte_queue
  import fetch_byte_queue_pkg::*;
#(
  parameter logic [31:0] RESET_EIP = 32'h0
) (
  input  logic                 clk,
  input  logic                 clr,
  fetch_byte_queue_if.slave    bus,
  output fq_state_e            dbg_state
);

  fq_state_e          state_q, state_d;
  logic [PTR_W-1:0]   rd_q, rd_d;
  logic [PTR_W-1:0]   wr_q, wr_d;
  logic [31:0]        eip_q, eip_d;
  logic [31:0]        fetch_q, fetch_d;
  logic [127:0]       slot_q [SLOTS];

  logic [PTR_W-1:0]   count;
  logic [PTR_W-1:0]   occupied;
  logic               accept;
  logic               do_consume;
  logic               wr_slot;

  // Bytes available from EIP; the first line's leading bytes before EIP do not count.
  assign count = (state_q == FQ_STREAM) ? (wr_q - rd_q) : '0;

  // A partially consumed slot still holds bytes, so occupancy is measured from the
  // start of the slot rd_q points into.
  assign occupied = wr_q - {rd_q[5:4], 4'b0000};

  assign bus.line_ready   = (state_q == FQ_WAIT_FIRST) || (occupied <= 6'(LINE_BYTES));
  assign bus.packet_valid = (state_q == FQ_STREAM) && (count >= 6'(LINE_BYTES));
  assign bus.packet_eip   = eip_q;
  assign bus.fetch_addr   = fetch_q;
  assign dbg_state        = state_q;

  assign accept     = bus.line_valid && bus.line_ready && (bus.line_addr == fetch_q)
                      && !bus.redirect;
  assign do_consume = bus.consume && bus.packet_valid && !bus.redirect;
  assign wr_slot    = (state_q == FQ_WAIT_FIRST) ? 1'b0 : wr_q[4];

  fetch_byte_queue_rotator u_rot (
    .data_in  ({slot_q[1], slot_q[0]}),
    .offset   (rd_q[4:0]),
    .data_out (bus.packet_out)
  );

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    eip_d   = eip_q;
    fetch_d = fetch_q;

    if (bus.redirect) begin
      state_d = FQ_WAIT_FIRST;
      rd_d    = '0;
      wr_d    = '0;
      eip_d   = bus.redirect_addr;
      fetch_d = line_base(bus.redirect_addr);
    end else begin
      if (accept) begin
        fetch_d = fetch_q + 32'd16;
        if (state_q == FQ_WAIT_FIRST) begin
          // First line lands in slot 0; reading starts at EIP's offset within it.
          state_d = FQ_STREAM;
          wr_d    = 6'd16;
          rd_d    = {2'b00, eip_q[3:0]};
        end else begin
          wr_d = wr_q + 6'd16;
        end
      end
      // Only possible in STREAM, so never collides with the first-line rd_d load.
      if (do_consume) begin
        rd_d  = rd_q + {1'b0, bus.consume_len};
        eip_d = eip_q + {27'd0, bus.consume_len};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= FQ_WAIT_FIRST;
      rd_q    <= '0;
      wr_q    <= '0;
      eip_q   <= RESET_EIP;
      fetch_q <= line_base(RESET_EIP);
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      eip_q   <= eip_d;
      fetch_q <= fetch_d;
    end
  end

  // Line storage needs no reset: pointers gate which bytes are ever presented.
  always_ff @(posedge clk) begin
    if (!clr && accept) begin
      slot_q[wr_slot] <= bus.line_data;
    end
  end

endmodule

// File: tb/tb_fetch_byte_queue.sv
module tb_fetch_byte_queue;
  import fetch_byte_queue_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  fetch_byte_queue_if bus ();
  fq_state_e dbg_state;

  fetch_byte_queue #(.RESET_EIP(32'h100)) dut (
    .clk       (clk),
    .clr       (clr),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [159:0] exp_q[$];
  logic [159:0] mon_exp;

  // Memory image: byte at address a. Lines at 0x1xx hold their low address byte.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] ^ {a[10:9], 6'b0};
  endfunction

  function automatic logic [127:0] window(input logic [31:0] a);
    logic [127:0] w;
    for (int k = 0; k < 16; k++) w[8*k +: 8] = mem_byte(a + 32'(k));
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic lv, input logic [31:0] la, input logic rd,
                       input logic [31:0] ra, input logic cs, input logic [4:0] cl,
                       input logic [31:0] exp_eip);
    bus.line_valid    = lv;
    bus.line_addr     = la;
    bus.line_data     = window(la);
    bus.redirect      = rd;
    bus.redirect_addr = ra;
    bus.consume       = cs;
    bus.consume_len   = cl;
    if (cs && !rd) exp_q.push_back({exp_eip, window(exp_eip)});
    @(posedge clk);
    #1;
    bus.line_valid = 1'b0;
    bus.redirect   = 1'b0;
    bus.consume    = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!clr && bus.consume && bus.packet_valid && !bus.redirect) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL packet_unexpected actual_eip=%h required=none", bus.packet_eip);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({bus.packet_eip, bus.packet_out} !== mon_exp) begin
          errors++;
          $display("FAIL packet actual=%h_%h required=%h_%h", bus.packet_eip,
                   bus.packet_out, mon_exp[159:128], mon_exp[127:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  logic [31:0] m_fetch, m_eip;
  int          sent;
  logic        lv, cs;

  initial begin
    clr = 1'b1;
    bus.line_valid = 1'b0; bus.line_addr = '0; bus.line_data = '0;
    bus.redirect = 1'b0; bus.redirect_addr = '0; bus.consume = 1'b0; bus.consume_len = '0;
    @(posedge clk); #1;
    clr = 1'b0;

    check("rst_valid", 32'(bus.packet_valid), 32'd0);
    check("rst_ready", 32'(bus.line_ready), 32'd1);
    check("rst_fetch", bus.fetch_addr, 32'h100);
    check("rst_eip", bus.packet_eip, 32'h100);
    check("rst_state", 32'(dbg_state), 32'(FQ_WAIT_FIRST));

    // first aligned line fills a whole window
    drive(1'b1, 32'h100, 1'b0, '0, 1'b0, 5'd0, '0);
    check("t1_valid", 32'(bus.packet_valid), 32'd1);
    check("t1_b0", 32'(bus.packet_out[7:0]), 32'h00);
    check("t1_b15", 32'(bus.packet_out[127:120]), 32'h0F);
    check("t1_eip", bus.packet_eip, 32'h100);
    check("t1_fetch", bus.fetch_addr, 32'h110);

    // consume 3 while accepting the next line
    drive(1'b1, 32'h110, 1'b0, '0, 1'b1, 5'd3, 32'h100);
    check("t2_eip", bus.packet_eip, 32'h103);
    check("t2_b0", 32'(bus.packet_out[7:0]), 32'h03);
    check("t2_b15", 32'(bus.packet_out[127:120]), 32'h12);
    check("t2_valid", 32'(bus.packet_valid), 32'd1);
    check("t2_ready_full", 32'(bus.line_ready), 32'd0);
    check("t2_fetch", bus.fetch_addr, 32'h120);

    // redirect to an unaligned EIP
    drive(1'b0, '0, 1'b1, 32'h20A, 1'b0, 5'd0, '0);
    check("t3_valid", 32'(bus.packet_valid), 32'd0);
    check("t3_fetch", bus.fetch_addr, 32'h200);
    check("t3_eip", bus.packet_eip, 32'h20A);
    check("t3_ready", 32'(bus.line_ready), 32'd1);

    // stale response from before the redirect
    drive(1'b1, 32'h120, 1'b0, '0, 1'b0, 5'd0, '0);
    check("t4_fetch", bus.fetch_addr, 32'h200);
    check("t4_state", 32'(dbg_state), 32'(FQ_WAIT_FIRST));

    drive(1'b1, 32'h200, 1'b0, '0, 1'b0, 5'd0, '0);
    check("t3_partial_valid", 32'(bus.packet_valid), 32'd0);
    check("t3_partial_fetch", bus.fetch_addr, 32'h210);
    drive(1'b1, 32'h210, 1'b0, '0, 1'b0, 5'd0, '0);
    check("t3_second_valid", 32'(bus.packet_valid), 32'd1);
    check("t3_second_b0", 32'(bus.packet_out[7:0]), 32'h4A);
    check("t3_second_eip", bus.packet_eip, 32'h20A);

    // full: third line ignored, then consume 16 frees a slot
    check("t5_ready_full", 32'(bus.line_ready), 32'd0);
    drive(1'b1, 32'h220, 1'b0, '0, 1'b0, 5'd0, '0);
    check("t5_fetch_held", bus.fetch_addr, 32'h220);
    drive(1'b0, '0, 1'b0, '0, 1'b1, 5'd16, 32'h20A);
    check("t5_ready_free", 32'(bus.line_ready), 32'd1);
    check("t5_eip", bus.packet_eip, 32'h21A);
    check("t5_valid", 32'(bus.packet_valid), 32'd0);

    // streaming consume 15 over 8 lines, wrapping the store
    m_fetch = 32'h220;
    m_eip   = 32'h21A;
    sent    = 0;
    for (int it = 0; it < 100 && (sent < 8 || (m_fetch - m_eip) >= 32'd16); it++) begin
      lv = (sent < 8) && ((m_fetch - (m_eip & ~32'hF)) <= 32'd16);
      cs = (m_fetch - m_eip) >= 32'd16;
      drive(lv, m_fetch, 1'b0, '0, cs, 5'd15, m_eip);
      if (lv) begin m_fetch += 32'd16; sent++; end
      if (cs) m_eip += 32'd15;
      check("t6_valid", 32'(bus.packet_valid), 32'((m_fetch - m_eip) >= 32'd16));
      check("t6_ready", 32'(bus.line_ready), 32'((m_fetch - (m_eip & ~32'hF)) <= 32'd16));
    end
    check("t6_eip", bus.packet_eip, m_eip);

    // redirect beats consume and a matching line in the same cycle
    drive(1'b0, '0, 1'b1, 32'h300, 1'b0, 5'd0, '0);
    drive(1'b1, 32'h300, 1'b0, '0, 1'b0, 5'd0, '0);
    check("t7_pre_valid", 32'(bus.packet_valid), 32'd1);
    drive(1'b1, 32'h310, 1'b1, 32'h345, 1'b1, 5'd4, '0);
    check("t7_eip", bus.packet_eip, 32'h345);
    check("t7_valid", 32'(bus.packet_valid), 32'd0);
    check("t7_fetch", bus.fetch_addr, 32'h340);
    drive(1'b1, 32'h340, 1'b0, '0, 1'b0, 5'd0, '0);
    check("t7_partial_valid", 32'(bus.packet_valid), 32'd0);
    drive(1'b1, 32'h350, 1'b0, '0, 1'b0, 5'd0, '0);
    check("t7_second_valid", 32'(bus.packet_valid), 32'd1);
    drive(1'b0, '0, 1'b0, '0, 1'b1, 5'd16, 32'h345);
    check("t7_eip_after", bus.packet_eip, 32'h355);

    // reset mid-stream discards everything
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("rst2_valid", 32'(bus.packet_valid), 32'd0);
    check("rst2_eip", bus.packet_eip, 32'h100);
    check("rst2_fetch", bus.fetch_addr, 32'h100);
    check("rst2_ready", 32'(bus.line_ready), 32'd1);

    @(posedge clk); #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
